// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard/forwarding controller for the 5-stage RV32 core. It tracks one
//   multi-cycle unit (mul/div) issued from EXE through a per-register pending
//   scoreboard and a latency countdown. It stalls on load-use, scoreboard RAW,
//   WAW and structural hazards, or on every RAW when forwarding is disabled. It
//   also counts stall cycles and drives the EXE operand-mux selects.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   Branch_ID                      taken branch/jump resolved in ID
//   rs1use_ID, rs2use_ID           ID instruction reads rs1/rs2
//   rs1_ID, rs2_ID, rd_ID          ID register indices
//   RegWrite_ID, mc_op_ID          ID writes rd / ID is a multi-cycle op
//   rd_EXE, rs2_EXE                EXE destination / store-data source
//   RegWrite_EXE, DatatoReg_EXE, mem_w_EXE   EXE writes rd / is load / is store
//   rd_MEM, RegWrite_MEM, DatatoReg_MEM      MEM destination / writes rd / is load
//   PC_EN_IF .. reg_MW_EN          pipeline enables, stalls and flushes
//   forward_ctrl_A/B               00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load
//   forward_ctrl_ls                store data in EXE taken from MEM load data
//   mc_busy, mc_wb_valid, mc_rd    multi-cycle unit status
//   stall_count                    saturating stall-cycle counter
module hazard_scoreboard_unit #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned MC_LAT  = 4,
    parameter int unsigned FORWARD = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Branch_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [RW-1:0]    rs1_ID,
    input  logic [RW-1:0]    rs2_ID,
    input  logic [RW-1:0]    rd_ID,
    input  logic             RegWrite_ID,
    input  logic             mc_op_ID,
    input  logic [RW-1:0]    rd_EXE,
    input  logic [RW-1:0]    rs2_EXE,
    input  logic             RegWrite_EXE,
    input  logic             DatatoReg_EXE,
    input  logic             mem_w_EXE,
    input  logic [RW-1:0]    rd_MEM,
    input  logic             RegWrite_MEM,
    input  logic             DatatoReg_MEM,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_stall,
    output logic             reg_FD_flush,
    output logic             reg_DE_EN,
    output logic             reg_DE_flush,
    output logic             reg_EM_EN,
    output logic             reg_EM_flush,
    output logic             reg_MW_EN,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic             mc_busy,
    output logic             mc_wb_valid,
    output logic [RW-1:0]    mc_rd,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned CW = $clog2(MC_LAT + 1);
    localparam logic [CW-1:0] CntLoad = CW'(MC_LAT);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    logic [NREG-1:0]  pending_q, pending_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    mc_rd_q, mc_rd_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic rd_a, rd_b;
    logic ex_a, ex_b, mem_a, mem_b;
    logic load_use, raw_nofwd, raw_pending, waw, struct_haz, stall, issue;

    // x0 is never a real source, so it can neither hazard nor forward.
    assign rd_a  = rs1use_ID & (rs1_ID != '0);
    assign rd_b  = rs2use_ID & (rs2_ID != '0);
    assign ex_a  = RegWrite_EXE & (rd_EXE == rs1_ID);
    assign ex_b  = RegWrite_EXE & (rd_EXE == rs2_ID);
    assign mem_a = RegWrite_MEM & (rd_MEM == rs1_ID);
    assign mem_b = RegWrite_MEM & (rd_MEM == rs2_ID);

    assign load_use    = DatatoReg_EXE & ((rd_a & ex_a) | (rd_b & ex_b));
    assign raw_nofwd   = (FORWARD == 0) &&
                         ((rd_a && (ex_a || mem_a)) || (rd_b && (ex_b || mem_b)));
    assign raw_pending = (rd_a & pending_q[rs1_ID]) | (rd_b & pending_q[rs2_ID]);
    assign waw         = RegWrite_ID & (rd_ID != '0) & pending_q[rd_ID];
    // The unit can accept a new op in its write-back cycle (cnt == 1).
    assign struct_haz  = mc_op_ID & (cnt_q > CntOne);
    assign stall       = load_use | raw_nofwd | raw_pending | waw | struct_haz;
    assign issue       = mc_op_ID & ~stall;

    assign PC_EN_IF     = ~stall;
    assign reg_FD_stall = stall;
    assign reg_DE_flush = stall;
    assign reg_FD_flush = ~stall & Branch_ID;
    assign reg_FD_EN    = 1'b1;
    assign reg_DE_EN    = 1'b1;
    assign reg_EM_EN    = 1'b1;
    assign reg_MW_EN    = 1'b1;
    assign reg_EM_flush = 1'b0;

    assign forward_ctrl_ls = mem_w_EXE & RegWrite_MEM & DatatoReg_MEM &
                             (rs2_EXE != '0) & (rd_MEM == rs2_EXE);

    // EXE result is younger than MEM, so it wins.
    always_comb begin
        forward_ctrl_A = 2'b00;
        forward_ctrl_B = 2'b00;
        if (FORWARD != 0) begin
            if (rd_a) begin
                if (ex_a)       forward_ctrl_A = 2'b01;
                else if (mem_a) forward_ctrl_A = DatatoReg_MEM ? 2'b11 : 2'b10;
            end
            if (rd_b) begin
                if (ex_b)       forward_ctrl_B = 2'b01;
                else if (mem_b) forward_ctrl_B = DatatoReg_MEM ? 2'b11 : 2'b10;
            end
        end
    end

    assign mc_busy     = (cnt_q != '0);
    assign mc_wb_valid = (cnt_q == CntOne);
    assign mc_rd       = mc_rd_q;
    assign stall_count = stall_count_q;

    always_comb begin
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        mc_rd_d       = mc_rd_q;
        stall_count_d = stall_count_q;
        if (cnt_q != '0) cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) pending_d[mc_rd_q] = 1'b0;
        // A new issue is applied after the write-back clear so it wins on the same rd.
        if (issue) begin
            cnt_d   = CntLoad;
            mc_rd_d = rd_ID;
            if (RegWrite_ID && (rd_ID != '0)) pending_d[rd_ID] = 1'b1;
        end
        if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            cnt_q         <= '0;
            mc_rd_q       <= '0;
            stall_count_q <= '0;
        end else begin
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            mc_rd_q       <= mc_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
